// File: rtl/con_loader_if.sv
// Byte-stream and console-port bundle between con_loader and its environment.
// master: the loader side (consumes bytes, drives the console port).
// slave:  the environment side (byte source plus data memory).
interface con_loader_if #(
    parameter int ADDR_W = 11
);
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        con_write;
    logic [ADDR_W-1:0] con_addr;
    logic [31:0]       con_in;
    logic [31:0]       con_out;

    modport master (
        input  in_byte,
        input  in_valid,
        input  con_out,
        output in_ready,
        output con_write,
        output con_addr,
        output con_in
    );

    modport slave (
        output in_byte,
        output in_valid,
        output con_out,
        input  in_ready,
        input  con_write,
        input  con_addr,
        input  con_in
    );
endinterface

// File: rtl/con_loader.sv
// con_loader: assembles little-endian 32-bit words from a byte stream, writes
// each word to data memory through the console port, reads it back and
// verifies it. A mismatch aborts the load and records the failing address.
module con_loader #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 11
) (
    input  logic              CLK,
    input  logic              nrst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    con_loader_if.master      bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_READ,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [CNT_W-1:0]  remaining_reg, remaining_next;
    logic [1:0]        byte_idx_reg, byte_idx_next;
    logic              err_reg, err_next;
    logic [ADDR_W-1:0] err_addr_reg, err_addr_next;

    // One register per byte lane; lanes fill in stream order (byte 0 = LSB).
    logic [7:0]        word_bytes_reg [4];
    logic [31:0]       word;
    logic              transfer;
    logic [3:0]        lane_we;

    // A byte is consumed only while collecting and the source offers one.
    assign transfer = (state_reg == S_COLLECT) && bus.in_valid;
    assign word     = {word_bytes_reg[3], word_bytes_reg[2],
                       word_bytes_reg[1], word_bytes_reg[0]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = transfer && (byte_idx_reg == 2'(gi));

            // Capture the incoming byte into its lane; reset drops any partial word.
            always_ff @(posedge CLK) begin
                if (!nrst) begin
                    word_bytes_reg[gi] <= 8'h00;
                end else if (lane_we[gi]) begin
                    word_bytes_reg[gi] <= bus.in_byte;
                end
            end
        end
    endgenerate

    // State and bookkeeping registers.
    always_ff @(posedge CLK) begin
        if (!nrst) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            byte_idx_reg  <= 2'd0;
            err_reg       <= 1'b0;
            err_addr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            byte_idx_reg  <= byte_idx_next;
            err_reg       <= err_next;
            err_addr_reg  <= err_addr_next;
        end
    end

    // Next-state logic and the state-decoded console/stream outputs.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        byte_idx_next  = byte_idx_reg;
        err_next       = err_reg;
        err_addr_next  = err_addr_reg;
        bus.in_ready   = 1'b0;
        bus.con_write  = 4'h0;
        bus.con_addr   = '0;
        bus.con_in     = 32'h0;
        done           = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    addr_next      = base_addr;
                    remaining_next = num_words;
                    err_next       = 1'b0;
                    byte_idx_next  = 2'd0;
                    // An empty load still reports completion through FINISH.
                    state_next     = (num_words == '0) ? S_FINISH : S_COLLECT;
                end
            end
            S_COLLECT: begin
                bus.in_ready = 1'b1;
                bus.con_addr = addr_reg;
                if (transfer) begin
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                bus.con_write = 4'hF;
                bus.con_addr  = addr_reg;
                bus.con_in    = word;
                state_next    = S_READ;
            end
            S_READ: begin
                // Address held one cycle so the synchronous memory returns the word.
                bus.con_addr = addr_reg;
                state_next   = S_CHECK;
            end
            S_CHECK: begin
                bus.con_addr = addr_reg;
                if (bus.con_out != word) begin
                    // Abort: the rest of the stream is left unconsumed.
                    err_next      = 1'b1;
                    err_addr_next = addr_reg;
                    state_next    = S_FINISH;
                end else begin
                    addr_next      = addr_reg + 1'b1;
                    remaining_next = remaining_reg - 1'b1;
                    if (remaining_reg == CNT_W'(1)) begin
                        state_next = S_FINISH;
                    end else begin
                        byte_idx_next = 2'd0;
                        state_next    = S_COLLECT;
                    end
                end
            end
            S_FINISH: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_reg != S_IDLE);
    assign err      = err_reg;
    assign err_addr = err_addr_reg;

endmodule

// File: tb/tb_con_loader.sv
// Testbench for con_loader: randomized byte streams, a synchronous memory
// model on the console port, and a scoreboard fed by a word-level reference.
module tb_con_loader;
    localparam int ADDR_W = 11;
    localparam int CNT_W  = 11;

    logic              CLK = 1'b0;
    logic              nrst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  num_words = '0;
    logic              busy, done, err;
    logic [ADDR_W-1:0] err_addr;

    con_loader_if #(.ADDR_W(ADDR_W)) bus ();

    con_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .nrst      (nrst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .bus       (bus.master),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_addr  (err_addr)
    );

    always #5 CLK = ~CLK;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     consumed = 0;
    int     wr_count = 0;
    int     done_count = 0;

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- synchronous data memory ----------------
    logic [31:0]       mem [2048];
    bit                corrupt_en = 1'b0;
    logic [ADDR_W-1:0] corrupt_addr = '0;

    always @(posedge CLK) begin
        if (bus.con_write == 4'hF) mem[bus.con_addr] <= bus.con_in;
        bus.con_out <= mem[bus.con_addr] ^
                       ((corrupt_en && bus.con_addr == corrupt_addr) ? 32'h1 : 32'h0);
    end

    // ---------------- byte source ----------------
    logic [7:0] src_q[$];
    bit         gaps = 1'b0;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        forever begin
            @(posedge CLK);
            #1;
            if (src_q.size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
                bus.in_valid = 1'b1;
                bus.in_byte  = src_q[0];
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge CLK);
            if (bus.in_valid && bus.in_ready && nrst) begin
                void'(src_q.pop_front());
                consumed++;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;
    typedef struct {
        logic              e;
        logic [ADDR_W-1:0] ea;
        longint            at;
    } dn_t;

    wr_t               wr_q[$];
    dn_t               dn_q[$];
    logic [ADDR_W-1:0] model_err_addr = '0;

    // Monitor: every console write and every done pulse is matched to the queue.
    always @(negedge CLK) begin
        if (nrst) begin
            if (bus.con_write != 4'h0) begin
                wr_count++;
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h@%0h required=none", bus.con_in, bus.con_addr);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    $display("WRITE addr=%03h data=%08h", bus.con_addr, bus.con_in);
                    check("write_enable", bus.con_write, 4'hF);
                    check("write_addr", bus.con_addr, w.addr);
                    check("write_data", bus.con_in, w.data);
                end
            end
            if (done) begin
                done_count++;
                if (dn_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    dn_t d;
                    d = dn_q.pop_front();
                    $display("DONE err=%0d err_addr=%03h cycle=%0d", err, err_addr, cyc);
                    check("done_err", err, d.e);
                    check("done_err_addr", err_addr, d.ea);
                    if (d.at >= 0) check("done_cycle", cyc, d.at);
                end
            end
            if (!busy) begin
                check("idle_in_ready", bus.in_ready, 1'b0);
                check("idle_con_addr", bus.con_addr, '0);
            end
            if (bus.con_write != 4'h0) check("write_in_ready", bus.in_ready, 1'b0);
        end
    end

    // Reference: word i of a load goes to (base+i) mod 2^ADDR_W as the
    // little-endian packing of stream bytes 4i..4i+3; the load stops at the
    // first word whose readback is corrupted.
    task automatic run_load(input logic [ADDR_W-1:0] base, input int n, input bit fixed_pattern,
                            input bit use_gaps, input int extra_bytes, input bit poke);
        logic [7:0]        b[$];
        logic [ADDR_W-1:0] a;
        logic              e;
        int                used;
        int                d0;
        int                wr0;
        int                k;
        int                budget;
        longint            exp_at;
        e    = 1'b0;
        used = 0;
        for (int i = 0; i < 4 * n + extra_bytes; i++)
            b.push_back(fixed_pattern ? 8'(8'h11 * (i + 1)) : 8'($urandom));
        for (int i = 0; i < n && !e; i++) begin
            a = base + ADDR_W'(i);
            wr_q.push_back('{addr: a, data: {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]}});
            used += 4;
            if (corrupt_en && a == corrupt_addr) begin
                e = 1'b1;
                model_err_addr = a;
            end
        end
        gaps     = use_gaps;
        consumed = 0;
        foreach (b[i]) src_q.push_back(b[i]);
        wr0 = wr_count;
        d0  = done_count;
        @(posedge CLK);
        #1;
        exp_at = (use_gaps || e) ? -1 : cyc + 1 + 7 * n;
        dn_q.push_back('{e: e, ea: model_err_addr, at: exp_at});
        start     = 1'b1;
        base_addr = base;
        num_words = CNT_W'(n);
        @(posedge CLK);
        #1;
        start = 1'b0;
        budget = 200 + 40 * n;
        k = 0;
        while (done_count == d0 && k < budget) begin
            @(negedge CLK);
            k++;
            if (poke && k == 5) begin
                start     = 1'b1;
                base_addr = 11'h555;
                num_words = CNT_W'(3);
            end else if (poke && k == 6) begin
                start = 1'b0;
            end
        end
        if (done_count == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=none required=done within %0d cycles", budget);
        end
        check("bytes_consumed", consumed, used);
        check("write_count", wr_count - wr0, used / 4);
        $display("LOAD base=%03h words=%0d gaps=%0d bytes=%0d err=%0d", base, n, use_gaps, consumed, e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_err_addr"}, err_addr, '0);
        check({tag, "_in_ready"}, bus.in_ready, 1'b0);
        check({tag, "_con_write"}, bus.con_write, 4'h0);
        check({tag, "_con_addr"}, bus.con_addr, '0);
        check({tag, "_con_in"}, bus.con_in, 32'h0);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("reset");
        @(posedge CLK);
        #1;
        nrst = 1'b1;

        // Fixed pattern, two words, back-to-back stream.
        run_load(11'h000, 2, 1'b1, 1'b0, 0, 1'b0);
        check("mem0", mem[0], 32'h44332211);
        check("mem1", mem[1], 32'h88776655);

        // Gappy stream, 16 words.
        run_load(11'h3F8, 16, 1'b0, 1'b1, 0, 1'b0);

        // Corrupted readback at 0x013 aborts the load.
        corrupt_en   = 1'b1;
        corrupt_addr = 11'h013;
        run_load(11'h010, 6, 1'b0, 1'b0, 0, 1'b0);
        repeat (10) @(negedge CLK);
        check("abort_consumed_after", consumed, 16);
        check("abort_bytes_left", src_q.size(), 8);
        check("err_sticky", err, 1'b1);
        src_q.delete();
        corrupt_en = 1'b0;

        // Empty load, then a start poked mid-load.
        run_load(11'h123, 0, 1'b0, 1'b0, 0, 1'b0);
        run_load(11'h200, 3, 1'b0, 1'b0, 0, 1'b1);
        repeat (30) @(negedge CLK);
        check("poke_no_relaunch", busy, 1'b0);

        // Address wrap.
        run_load(11'h7FF, 2, 1'b0, 1'b0, 0, 1'b0);
        check("wrap_mem_7ff", mem[11'h7FF], {src_dummy_bytes(0)});
        check("wrap_mem_000", mem[0], {src_dummy_bytes(1)});

        // Reset after two bytes of the first word.
        for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom));
        gaps     = 1'b0;
        consumed = 0;
        wr_q.push_back('{addr: 11'h100, data: 32'h0});
        dn_q.push_back('{e: 1'b0, ea: model_err_addr, at: -1});
        @(posedge CLK);
        #1;
        start     = 1'b1;
        base_addr = 11'h100;
        num_words = CNT_W'(2);
        @(posedge CLK);
        #1;
        start = 1'b0;
        k = 0;
        while (consumed < 2 && k < 50) begin
            @(negedge CLK);
            k++;
        end
        check("pre_reset_consumed", consumed, 2);
        @(posedge CLK);
        #1;
        nrst = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("midreset");
        wr_q.delete();
        dn_q.delete();
        src_q.delete();
        model_err_addr = '0;
        @(posedge CLK);
        #1;
        nrst = 1'b1;
        run_load(11'h100, 2, 1'b0, 1'b0, 0, 1'b0);

        // A few random loads.
        for (int t = 0; t < 4; t++)
            run_load(ADDR_W'($urandom), $urandom_range(1, 5), 1'b0, 1'($urandom_range(0, 1)), 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Words written by the wrap load, recorded from the scoreboard as it is filled.
    logic [31:0] wrap_words [2];
    function automatic logic [31:0] src_dummy_bytes(input int idx);
        return wrap_words[idx];
    endfunction

    // Capture expected words of writes targeting 0x7FF and its successor 0x000
    // when they are pushed, independently of the DUT.
    always @(negedge CLK) begin
        if (wr_q.size() > 0) begin
            foreach (wr_q[i]) begin
                if (wr_q[i].addr == 11'h7FF) wrap_words[0] = wr_q[i].data;
                else if (wr_q[i].addr == 11'h000 && i > 0 && wr_q[i-1].addr == 11'h7FF)
                    wrap_words[1] = wr_q[i].data;
            end
        end
    end

endmodule

// File: doc/con_loader.md
# con_loader

Byte-stream loader that writes 32-bit words into the core's data memory through the console port (con_write/con_addr/con_in/con_out), then reads each word back and verifies it. It sits between a byte source (UART receiver or bench driver) and the core's console port, and is the write-side counterpart of the console read-out used for answer-key checking. A load is started by a one-cycle start pulse and ends with a done pulse and a sticky error flag.

## Interface
- ADDR_W, 11: console word-address width (`DATAMEM_BITS`+1).
- CNT_W, 11: word-count width.
- CLK  in  1  clock; all state updates on the rising edge.
- nrst  in  1  reset, synchronous, active-low; clock CLK.
- start  in  1  one-cycle pulse; latches base_addr and num_words; ignored unless state is IDLE.
- base_addr  in  ADDR_W  first word address.
- num_words  in  CNT_W  words to load; 0 is legal.
- in_byte  in  8  stream data byte.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  loader accepts a byte; a transfer is in_valid&&in_ready on a rising edge.
- con_write  out  4  byte-write enables to data memory.
- con_addr  out  ADDR_W  console word address.
- con_in  out  32  write data.
- con_out  in  32  read data; synchronous memory, valid one cycle after con_addr is presented.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a load.
- err  out  1  sticky verify-mismatch flag; cleared by the next accepted start.
- err_addr  out  ADDR_W  address of the first mismatch.

## Operation
- States: IDLE, COLLECT, WRITE, READ, CHECK, FINISH.
- IDLE: on start, addr<=base_addr, remaining<=num_words, err<=0, byte_idx<=0. If num_words==0, go to FINISH; otherwise go to COLLECT.
- COLLECT: in_ready=1. Each transfer stores in_byte into word bits [8*byte_idx+7:8*byte_idx] (little-endian) and increments byte_idx. The transfer with byte_idx==3 goes to WRITE.
- WRITE: con_write=4'hF, con_addr=addr, con_in=word for exactly one cycle. Next state is READ.
- READ: con_write=0, con_addr=addr. Wait one cycle for memory read latency. Next state is CHECK.
- CHECK: compare con_out with word.
  - On mismatch: err<=1, err_addr<=addr, go to FINISH (abort; remaining words are not consumed).
  - On match: addr<=addr+1 (wraps modulo 2^ADDR_W), remaining<=remaining-1. If remaining==1, go to FINISH; otherwise go to COLLECT with byte_idx<=0.
- FINISH: done=1 for one cycle, then IDLE.
- in_ready=0 in every state except COLLECT. Bytes offered outside COLLECT are not consumed.
- con_write is nonzero only in WRITE.
- con_addr holds addr in COLLECT, WRITE, READ and CHECK; it is 0 in IDLE. The core's console address is therefore free while IDLE.

## Timing
- Reset values: state IDLE, in_ready 0, con_write 0, con_addr 0, con_in 0, busy 0, done 0, err 0, err_addr 0, byte_idx 0.
- Per-word latency with in_valid held high: 4 COLLECT cycles + WRITE + READ + CHECK = 7 cycles.
- A load of N words with an uninterrupted stream takes 1 (start) + 7N + 1 (FINISH) cycles from start to the done pulse.
- num_words==0: done asserts exactly 2 cycles after start.
- A start pulse while busy is ignored; parameters are not re-latched.
- in_valid gaps stall COLLECT indefinitely. There is no timeout.
- Address wrap: base_addr=2^ADDR_W-1 with 2 words writes 0x7FF, then 0x000.
- Reset asserted mid-load returns to IDLE on the next rising edge. A partial word is discarded; a word already written stays in memory.
- err and err_addr hold after done until the next accepted start.

## Test plan
- Reset, then start base 0x000, count 2, stream 11 22 33 44 55 66 77 88 -> mem[0]=0x44332211, mem[1]=0x88776655, done at cycle 16 after start, err=0.
- Random in_valid gaps (50% duty), 16 words from base 0x3F8 -> all words correct; in_ready only in COLLECT; con_write=F for exactly 16 single cycles.
- Memory model forcing a corrupted readback at word 3, base 0x010 -> err=1, err_addr=0x013, done pulses; bytes after word 3 are not consumed (in_ready stays 0).
- num_words=0 -> done 2 cycles after start, no con_write activity; a start during a load is ignored and the load completes as originally specified.
- base 0x7FF, count 2 -> writes to 0x7FF then 0x000.
- nrst asserted after 2 bytes of word 0 -> all outputs return to reset values next cycle; a fresh load then completes cleanly.
